// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings for the TLB-management sequencer: op types, the packed 78-bit
// entry layout and the controller's state set.
package tlb_op_ctrl_pkg;

  localparam logic [1:0] TLBOP_P   = 2'b00;
  localparam logic [1:0] TLBOP_R   = 2'b01;
  localparam logic [1:0] TLBOP_WI  = 2'b10;
  localparam logic [1:0] TLBOP_RSV = 2'b11;

  localparam int unsigned EntryW    = 78;
  localparam int unsigned EntVpn2Hi = 77;
  localparam int unsigned EntVpn2Lo = 59;
  localparam int unsigned EntAsidHi = 58;
  localparam int unsigned EntAsidLo = 51;
  localparam int unsigned EntG      = 50;
  localparam int unsigned EntLo0Hi  = 49;
  localparam int unsigned EntLo0Lo  = 25;
  localparam int unsigned EntLo1Hi  = 24;
  localparam int unsigned EntLo1Lo  = 0;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [24:0] lo0;  // PFN0/C0/D0/V0
    logic [24:0] lo1;  // PFN1/C1/D1/V1
  } tlb_entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StProbe,
    StPwr,
    StRead,
    StRwr,
    StWrite,
    StFlush
  } state_e;

  // CP0 Index value after a probe: P bit set on miss, index field only on hit.
  function automatic logic [31:0] probe_index(logic found, logic [4:0] idx);
    return {~found, 26'd0, (found ? idx : 5'd0)};
  endfunction

endpackage

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI between WB, CP0 and the TLB array, stalling the pipeline
// for the op's duration and finishing with a refetch flush to PC+4.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  localparam int unsigned IDXW  = $clog2(TLBNUM)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                op_valid,
  input  logic [1:0]          op_type,
  input  logic [31:0]         op_pc,
  output logic                stall,
  output logic                op_done,
  input  logic [31:0]         cp0_entryhi,
  input  logic [IDXW-1:0]     cp0_index,
  input  logic [EntryW-1:0]   cp0_tlbwi_entry,
  output logic                tlbp_wen,
  output logic [31:0]         tlbp_index,
  output logic                tlbr_wen,
  output logic [EntryW-1:0]   tlbr_entry,
  output logic [18:0]         s_vpn2,
  output logic [7:0]          s_asid,
  input  logic                s_found,
  input  logic [IDXW-1:0]     s_index,
  output logic [IDXW-1:0]     r_index,
  input  logic [EntryW-1:0]   r_entry,
  output logic                w_en,
  output logic [IDXW-1:0]     w_index,
  output logic [EntryW-1:0]   w_entry,
  output logic                flush,
  output logic [31:0]         flush_pc
);

  state_e              state_q, state_d;
  logic [31:0]         pc_q;
  logic [31:0]         pidx_q;
  logic [EntryW-1:0]   ent_q;

  logic                accept;
  logic                unused_entryhi;

  assign accept         = (state_q == StIdle) && op_valid;
  assign unused_entryhi = ^cp0_entryhi[12:8];

  // Search and read ports are driven continuously; the TLB answers combinationally.
  assign s_vpn2  = cp0_entryhi[31:13];
  assign s_asid  = cp0_entryhi[7:0];
  assign r_index = cp0_index;
  assign w_index = cp0_index;
  assign w_entry = cp0_tlbwi_entry;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q   <= '0;
      pidx_q <= '0;
      ent_q  <= '0;
    end else begin
      if (accept) begin
        pc_q <= op_pc;
      end
      if (state_q == StProbe) begin
        pidx_q <= probe_index(s_found, 5'(s_index));
      end
      if (state_q == StRead) begin
        ent_q <= r_entry;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          unique case (op_type)
            TLBOP_P:  state_d = StProbe;
            TLBOP_R:  state_d = StRead;
            TLBOP_WI: state_d = StWrite;
            default:  state_d = StFlush;
          endcase
        end
      end
      StProbe: state_d = StPwr;
      StPwr:   state_d = StFlush;
      StRead:  state_d = StRwr;
      StRwr:   state_d = StFlush;
      StWrite: state_d = StFlush;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // resetn gates stall so an op_valid seen during reset cannot hold the pipe.
  always_comb begin
    stall      = resetn && (accept || ((state_q != StIdle) && (state_q != StFlush)));
    op_done    = (state_q == StFlush);
    flush      = (state_q == StFlush);
    flush_pc   = (state_q == StFlush) ? (pc_q + 32'd4) : 32'd0;
    tlbp_wen   = (state_q == StPwr);
    tlbp_index = pidx_q;
    tlbr_wen   = (state_q == StRwr);
    tlbr_entry = ent_q;
    w_en       = (state_q == StWrite);
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: drives the CP0 and TLB sides by hand and checks
// strobes, indices, entries, stall and flush cycle by cycle.
module tb_tlb_op_ctrl;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDXW   = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              op_valid;
  logic [1:0]        op_type;
  logic [31:0]       op_pc;
  logic              stall, op_done;
  logic [31:0]       cp0_entryhi;
  logic [IDXW-1:0]   cp0_index;
  logic [77:0]       cp0_tlbwi_entry;
  logic              tlbp_wen, tlbr_wen, w_en, flush;
  logic [31:0]       tlbp_index, flush_pc;
  logic [77:0]       tlbr_entry, r_entry, w_entry;
  logic [18:0]       s_vpn2;
  logic [7:0]        s_asid;
  logic              s_found;
  logic [IDXW-1:0]   s_index, r_index, w_index;

  int tests = 0;
  int fails = 0;

  localparam logic [77:0] RdEnt = {19'h2ABCD, 8'h5A, 1'b1, 25'h0123456, 25'h0654321};
  localparam logic [77:0] WrEnt = {19'h1F0F0, 8'hC3, 1'b0, 25'h1ABCDEF, 25'h0F00F00};

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .op_valid        (op_valid),
    .op_type         (op_type),
    .op_pc           (op_pc),
    .stall           (stall),
    .op_done         (op_done),
    .cp0_entryhi     (cp0_entryhi),
    .cp0_index       (cp0_index),
    .cp0_tlbwi_entry (cp0_tlbwi_entry),
    .tlbp_wen        (tlbp_wen),
    .tlbp_index      (tlbp_index),
    .tlbr_wen        (tlbr_wen),
    .tlbr_entry      (tlbr_entry),
    .s_vpn2          (s_vpn2),
    .s_asid          (s_asid),
    .s_found         (s_found),
    .s_index         (s_index),
    .r_index         (r_index),
    .r_entry         (r_entry),
    .w_en            (w_en),
    .w_index         (w_index),
    .w_entry         (w_entry),
    .flush           (flush),
    .flush_pc        (flush_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Strobe vector {tlbp_wen, tlbr_wen, w_en, flush, op_done, stall}.
  function automatic logic [5:0] ctl();
    return {tlbp_wen, tlbr_wen, w_en, flush, op_done, stall};
  endfunction

  initial begin
    resetn          = 1'b0;
    op_valid        = 1'b1;
    op_type         = 2'b00;
    op_pc           = 32'h0;
    cp0_entryhi     = 32'h0;
    cp0_index       = '0;
    cp0_tlbwi_entry = '0;
    s_found         = 1'b0;
    s_index         = '0;
    r_entry         = '0;
    #12;
    chk("reset_ctl", 78'(ctl()), 78'(6'b000000));
    chk("reset_tlbp_index", 78'(tlbp_index), 78'h0);
    chk("reset_tlbr_entry", tlbr_entry, 78'h0);
    chk("reset_flush_pc", 78'(flush_pc), 78'h0);
    op_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // TLBP hit
    cyc();
    cp0_entryhi = 32'h0040_2005;
    s_found     = 1'b1;
    s_index     = 4'd5;
    op_valid    = 1'b1;
    op_type     = 2'b00;
    op_pc       = 32'h0000_1000;
    #1;
    chk("p_hit_vpn2", 78'(s_vpn2), 78'h201);
    chk("p_hit_asid", 78'(s_asid), 78'h05);
    chk("p_hit_T_ctl", 78'(ctl()), 78'(6'b000001));
    cyc();
    op_valid = 1'b0;
    #1;
    chk("p_hit_T1_ctl", 78'(ctl()), 78'(6'b000001));
    cyc();
    chk("p_hit_T2_ctl", 78'(ctl()), 78'(6'b100001));
    chk("p_hit_T2_index", 78'(tlbp_index), 78'h5);
    cyc();
    chk("p_hit_T3_ctl", 78'(ctl()), 78'(6'b000110));
    chk("p_hit_T3_pc", 78'(flush_pc), 78'h1004);
    cyc();
    chk("p_hit_T4_ctl", 78'(ctl()), 78'(6'b000000));
    chk("p_hit_hold_index", 78'(tlbp_index), 78'h5);

    // TLBP miss
    s_found  = 1'b0;
    s_index  = 4'd7;
    op_valid = 1'b1;
    op_pc    = 32'h0000_2000;
    cyc();
    op_valid = 1'b0;
    #1;
    chk("p_miss_T1_ctl", 78'(ctl()), 78'(6'b000001));
    cyc();
    chk("p_miss_T2_ctl", 78'(ctl()), 78'(6'b100001));
    chk("p_miss_T2_index", 78'(tlbp_index), 78'h8000_0000);
    cyc();
    chk("p_miss_T3_ctl", 78'(ctl()), 78'(6'b000110));
    chk("p_miss_T3_pc", 78'(flush_pc), 78'h2004);

    // TLBR
    cyc();
    cp0_index = 4'd3;
    r_entry   = RdEnt;
    op_valid  = 1'b1;
    op_type   = 2'b01;
    op_pc     = 32'h0000_3000;
    #1;
    chk("r_T_ctl", 78'(ctl()), 78'(6'b000001));
    cyc();
    op_valid = 1'b0;
    #1;
    chk("r_T1_r_index", 78'(r_index), 78'h3);
    chk("r_T1_ctl", 78'(ctl()), 78'(6'b000001));
    cyc();
    r_entry = WrEnt;  // must not leak: entry was latched in READ
    #1;
    chk("r_T2_ctl", 78'(ctl()), 78'(6'b010001));
    chk("r_T2_entry", tlbr_entry, RdEnt);
    cyc();
    chk("r_T3_ctl", 78'(ctl()), 78'(6'b000110));
    chk("r_T3_pc", 78'(flush_pc), 78'h3004);

    // TLBWI at top of address space, then a reserved op back to back
    cyc();
    cp0_index       = 4'd15;
    cp0_tlbwi_entry = WrEnt;
    op_valid        = 1'b1;
    op_type         = 2'b10;
    op_pc           = 32'hFFFF_FFFC;
    #1;
    chk("wi_T_ctl", 78'(ctl()), 78'(6'b000001));
    cyc();
    op_type = 2'b00;  // op_valid stays high while busy: ignored
    #1;
    chk("wi_T1_ctl", 78'(ctl()), 78'(6'b001001));
    chk("wi_T1_index", 78'(w_index), 78'hF);
    chk("wi_T1_entry", w_entry, WrEnt);
    cyc();
    chk("wi_T2_ctl", 78'(ctl()), 78'(6'b000110));
    chk("wi_T2_pc", 78'(flush_pc), 78'h0);
    cyc();
    op_type = 2'b11;
    op_pc   = 32'h0000_4000;
    #1;
    chk("rsv_T_ctl", 78'(ctl()), 78'(6'b000001));
    cyc();
    op_valid = 1'b0;
    #1;
    chk("rsv_T1_ctl", 78'(ctl()), 78'(6'b000110));
    chk("rsv_T1_pc", 78'(flush_pc), 78'h4004);
    cyc();
    chk("rsv_T2_ctl", 78'(ctl()), 78'(6'b000000));

    // Reset during PWR
    s_found  = 1'b1;
    s_index  = 4'd9;
    op_valid = 1'b1;
    op_type  = 2'b00;
    op_pc    = 32'h0000_5000;
    cyc();
    op_valid = 1'b0;
    cyc();
    chk("rst_pwr_ctl", 78'(ctl()), 78'(6'b100001));
    chk("rst_pwr_index", 78'(tlbp_index), 78'h9);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_async_ctl", 78'(ctl()), 78'(6'b000000));
    chk("rst_async_index", 78'(tlbp_index), 78'h0);
    chk("rst_async_pc", 78'(flush_pc), 78'h0);
    cyc();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rst_after_ctl", 78'(ctl()), 78'(6'b000000));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences TLB-management instructions (TLBP, TLBR, TLBWI) between the writeback stage, the CP0 register file and the TLB array.
- Accepts one op from WB and stalls the pipeline while the op runs.
- Performs the TLB search, read or write, and the matching CP0 update, then issues a refetch flush to PC+4 so that later instructions see the new mapping.
- Sits beside CP0 in WB: it drives CP0's tlbp_wen/tlbp_index and tlbr_wen/tlbr_entry inputs, and it consumes CP0's entryhi, index and tlbwi_entry outputs.

Parameters:
TLBNUM, 16, number of TLB entries (power of two, 2..32)
IDXW, $clog2(TLBNUM), TLB index width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  asynchronous active-low reset
op_valid  in  1  WB holds a TLB op this cycle (already exception-free)
op_type  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 reserved
op_pc  in  32  PC of the op
stall  out  1  hold pipeline at WB and earlier
op_done  out  1  one-cycle pulse in the flush cycle; WB retires the op
cp0_entryhi  in  32  CP0 EntryHi
cp0_index  in  IDXW  CP0 Index low bits
cp0_tlbwi_entry  in  78  packed entry from CP0 (EntryHi/EntryLo0/EntryLo1)
tlbp_wen  out  1  CP0 Index write strobe
tlbp_index  out  32  value written to CP0 Index
tlbr_wen  out  1  CP0 EntryHi/Lo write strobe
tlbr_entry  out  78  packed entry to CP0
s_vpn2  out  19  TLB search VPN2
s_asid  out  8  TLB search ASID
s_found  in  1  TLB search hit (combinational from s_vpn2/s_asid)
s_index  in  IDXW  TLB search hit index
r_index  out  IDXW  TLB read index
r_entry  in  78  TLB read data (combinational from r_index)
w_en  out  1  TLB write strobe
w_index  out  IDXW  TLB write index
w_entry  out  78  TLB write data
flush  out  1  pipeline flush, one cycle
flush_pc  out  32  refetch target

Behaviour:
- Reset (async, resetn=0) forces state IDLE and clears all latched registers to 0.
- While in reset: stall, op_done, tlbp_wen, tlbr_wen, w_en and flush are 0; tlbp_index, tlbr_entry and flush_pc are 0.
- A reset asserted mid-op abandons the op. No strobe fires after reset and none is half-issued.
- States: IDLE, PROBE, PWR, READ, RWR, WRITE, FLUSH. State is one-hot or binary; the choice does not affect behaviour.
- IDLE: when op_valid=1, latch op_type and op_pc.
  - Next state: 00 -> PROBE, 01 -> READ, 10 -> WRITE, 11 -> FLUSH.
  - op_valid is sampled only in IDLE; it is ignored in every other state.
- PROBE:
  - s_vpn2 = cp0_entryhi[31:13]; s_asid = cp0_entryhi[7:0]. These outputs are driven continuously in all states.
  - Register found_q = s_found and idx_q = s_index.
  - Next state: PWR.
- PWR:
  - tlbp_wen=1.
  - tlbp_index = {~found_q, (31-IDXW) zeros, found_q ? idx_q : 0}.
  - Next state: FLUSH.
- READ:
  - r_index = cp0_index. This output is driven continuously.
  - Register ent_q = r_entry.
  - Next state: RWR.
- RWR:
  - tlbr_wen=1; tlbr_entry = ent_q.
  - Next state: FLUSH.
- WRITE:
  - w_en=1; w_index = cp0_index; w_entry = cp0_tlbwi_entry. The index and entry are sampled live in this cycle; CP0 is stable because the pipeline is stalled.
  - Next state: FLUSH.
- FLUSH:
  - flush=1; op_done=1.
  - flush_pc = latched pc + 32'd4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - Next state: IDLE.
- stall = (state==IDLE && op_valid) || (state!=IDLE && state!=FLUSH). stall is 0 in the FLUSH cycle so that WB retires the op.
- Latency from the accept cycle T to the flush cycle: TLBP T+3, TLBR T+3, TLBWI T+2, reserved T+1.
- Strobes tlbp_wen, tlbr_wen and w_en are mutually exclusive, and each lasts exactly one cycle per op.
- tlbp_index and tlbr_entry hold their last values outside the strobe cycles; receivers must qualify them with the strobes.
- Back-to-back ops: an op_valid present in the cycle after FLUSH is accepted. No IDLE bubble is needed beyond that cycle.

Decomposition:
- Shared package (mycpu.h):
  - op_type encodings: TLBOP_P, TLBOP_R, TLBOP_WI.
  - Bit-field positions of the 78-bit entry: VPN2 [77:59], ASID [58:51], G [50], PFN0/C0/D0/V0 [49:25], PFN1/C1/D1/V1 [24:0].
  - State encodings.
- No sub-module. The block is a single FSM plus latches.

Test Plan:
- TLBP hit: entryhi=0x00402005, TLB returns s_found=1, s_index=5 -> tlbp_wen at T+2 with tlbp_index=0x00000005; flush at T+3; flush_pc=op_pc+4; stall high T..T+2.
- TLBP miss: s_found=0, s_index=7 -> tlbp_index=0x80000000, single tlbp_wen pulse.
- TLBR: cp0_index=3, r_entry=78'h2ABCD_5A_1_0123456_0654321 -> r_index=3 in READ; tlbr_wen at T+2 carrying exactly that value; w_en never asserts.
- TLBWI at op_pc=0xFFFFFFFC: cp0_index=15 -> w_en at T+1 with w_index=15 and w_entry=cp0_tlbwi_entry; flush at T+2 with flush_pc=0x00000000.
- Back-to-back and reserved ops: TLBWI immediately followed by op_type=11 -> second op accepted the cycle after the first flush; reserved op flushes at T+1 with no strobe; op_valid toggling while busy has no effect.
- Reset mid-op: deassert resetn during PWR -> all outputs 0 immediately and asynchronously; after release, state is IDLE; no tlbp_wen and no flush.
